eeg_encrypted_record_writer: RTL and testbench

Storage-side counterpart of the EEG dataset reader. It accepts authenticated-encryption output (nonce, ciphertext blocks, auth tag) from the EEG data encryptor and writes it as self-describing records into a linear storage memory through a registered write port. Record layout at base address B: B = header {nonce[95:0], block_count[31:0]}; B+1..B+N = ciphertext; B+N+1 = tag. The header is written last, once N is known.

---
 rtl/eeg_storage_pkg.sv | 28 ++
 rtl/eeg_store_wport.sv | 37 +++
 rtl/eeg_encrypted_record_writer.sv | 147 ++++++++++++++
 tb/tb_eeg_encrypted_record_writer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_storage_pkg.sv
// Shared types and header-layout constants for the EEG encrypted record storage path.
package eeg_storage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_TAG,
    ST_HEADER,
    ST_DONE,
    ST_ABORT
  } record_state_t;

  // Source selector for the registered storage write stage
  typedef enum logic [1:0] {
    WSRC_NONE,
    WSRC_DATA,
    WSRC_TAG,
    WSRC_HDR
  } wsrc_t;

  localparam int unsigned HDR_NONCE_MSB     = 127;
  localparam int unsigned HDR_NONCE_LSB     = 32;
  localparam int unsigned HDR_COUNT_MSB     = 31;
  localparam int unsigned HDR_COUNT_LSB     = 0;
  localparam int unsigned MIN_RECORD_WORDS  = 3;
  localparam int unsigned RECORD_HDR_OFFSET = 0;

endpackage

// File: rtl/eeg_store_wport.sv
// Registered storage write port: one write per cycle, picked from data, tag or header.
module eeg_store_wport
  import eeg_storage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  wsrc_t                 sel,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] data_word,
  input  logic [DATA_WIDTH-1:0] tag_word,
  input  logic [DATA_WIDTH-1:0] hdr_word,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we   <= (sel != WSRC_NONE);
      mem_addr <= addr;
      case (sel)
        WSRC_DATA: mem_wdata <= data_word;
        WSRC_TAG:  mem_wdata <= tag_word;
        WSRC_HDR:  mem_wdata <= hdr_word;
        default:   mem_wdata <= mem_wdata;
      endcase
    end
  end

endmodule

// File: rtl/eeg_encrypted_record_writer.sv
// Writes nonce/ciphertext/tag streams as linear records: header at base, data, then tag.
module eeg_encrypted_record_writer
  import eeg_storage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned STORE_DEPTH = 1024,
  parameter int unsigned ADDR_W      = $clog2(STORE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  start_record,
  input  logic [95:0]           nonce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  tag_valid,
  output logic                  tag_ready,
  input  logic [127:0]          tag,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  full,
  output logic                  record_done,
  output logic [ADDR_W-1:0]     record_base,
  output logic [31:0]           record_words,
  output logic [31:0]           records_written,
  output logic                  error,
  output logic [ADDR_W:0]       free_words
);

  localparam int unsigned PW = ADDR_W + 1;

  record_state_t   state;
  logic [PW-1:0]   base_ptr;
  logic [PW-1:0]   wptr;
  logic [31:0]     count;
  logic [95:0]     nonce_q;
  wsrc_t           wsel;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_WIDTH-1:0] hdr_word;

  // Handshake and status decode straight from registered state
  assign in_ready   = (state == ST_DATA) && (wptr <= PW'(STORE_DEPTH - 2));
  assign tag_ready  = (state == ST_TAG);
  assign busy       = (state != ST_IDLE);
  assign free_words = PW'(STORE_DEPTH) - base_ptr;
  assign full       = (free_words < PW'(MIN_RECORD_WORDS));

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_NONCE_MSB:HDR_NONCE_LSB] = nonce_q;
    hdr_word[HDR_COUNT_MSB:HDR_COUNT_LSB] = count;
    wsel  = WSRC_NONE;
    waddr = ADDR_W'(wptr);
    case (state)
      ST_DATA:   if (in_valid && in_ready) wsel = WSRC_DATA;
      ST_TAG:    if (tag_valid) wsel = WSRC_TAG;
      ST_HEADER: begin
        wsel  = WSRC_HDR;
        waddr = ADDR_W'(base_ptr + PW'(RECORD_HDR_OFFSET));
      end
      default: ;
    endcase
  end

  eeg_store_wport #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_wport (
    .clk      (clk),
    .rst      (rst),
    .sel      (wsel),
    .addr     (waddr),
    .data_word(in_data),
    .tag_word (DATA_WIDTH'(tag)),
    .hdr_word (hdr_word),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      base_ptr        <= '0;
      wptr            <= '0;
      count           <= '0;
      nonce_q         <= '0;
      record_done     <= 1'b0;
      record_base     <= '0;
      record_words    <= '0;
      records_written <= '0;
      error           <= 1'b0;
    end else begin
      record_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear) begin
            base_ptr        <= '0;
            records_written <= '0;
            error           <= 1'b0;
          end else if (start_record) begin
            if (full) begin
              error <= 1'b1;
            end else begin
              nonce_q <= nonce;
              wptr    <= base_ptr + PW'(1);
              count   <= '0;
              error   <= 1'b0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (in_valid && in_ready) begin
            wptr  <= wptr + PW'(1);
            count <= count + 32'd1;
            if (in_last) state <= ST_TAG;
          end else if (in_valid) begin
            // Only the tag slot is left and the stream is still going
            error <= 1'b1;
            state <= ST_ABORT;
          end
        end
        ST_TAG: begin
          if (tag_valid) state <= ST_HEADER;
        end
        ST_HEADER: begin
          record_done     <= 1'b1;
          record_base     <= ADDR_W'(base_ptr);
          record_words    <= count + 32'd2;
          records_written <= records_written + 32'd1;
          state           <= ST_DONE;
        end
        ST_DONE: begin
          base_ptr <= wptr + PW'(1);
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeg_encrypted_record_writer.sv
// Randomised record-writer bench against a record-level model of the storage image.
module tb_eeg_encrypted_record_writer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           rst, clear, start_record;
  logic [95:0]    nonce_in;
  logic           in_valid, in_last, tag_valid;
  logic [127:0]   in_data, tag_in;
  logic           in_ready, tag_ready, mem_we, busy, full, record_done, error;
  logic [AW-1:0]  mem_addr, record_base;
  logic [127:0]   mem_wdata;
  logic [31:0]    record_words, records_written;
  logic [AW:0]    free_words;

  always #5 clk = ~clk;

  eeg_encrypted_record_writer #(
    .DATA_WIDTH (128),
    .STORE_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .start_record   (start_record),
    .nonce          (nonce_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .tag_valid      (tag_valid),
    .tag_ready      (tag_ready),
    .tag            (tag_in),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .busy           (busy),
    .full           (full),
    .record_done    (record_done),
    .record_base    (record_base),
    .record_words   (record_words),
    .records_written(records_written),
    .error          (error),
    .free_words     (free_words)
  );

  int checks = 0;
  int failures = 0;

  // Record-level model: next free base, committed count, sticky error
  int           m_base, m_rw;
  logic         m_err;
  int           exp_addr[$];
  logic [127:0] exp_data[$];
  int           exp_rbase[$];
  int           exp_rwords[$];
  logic [127:0] blk[32];
  logic [127:0] tag_word;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_excl", 128'(in_ready & tag_ready), 128'(0));
      if (mem_we) begin
        if (exp_addr.size() == 0) check("spurious_we", 128'(mem_we), 128'(0));
        else begin
          check("wr_addr", 128'(mem_addr), 128'(exp_addr[0]));
          check("wr_data", mem_wdata, exp_data[0]);
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
      end
      if (record_done) begin
        if (exp_rbase.size() == 0) check("spurious_done", 128'(record_done), 128'(0));
        else begin
          check("rec_base", 128'(record_base), 128'(exp_rbase[0]));
          check("rec_words", 128'(record_words), 128'(exp_rwords[0]));
          void'(exp_rbase.pop_front());
          void'(exp_rwords.pop_front());
        end
      end
    end
  end

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    tag_word = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (exp_addr.size() != 0 || exp_rbase.size() != 0); i++) @(negedge clk);
    check("drain_wr", 128'(exp_addr.size()), 128'(0));
    check("drain_done", 128'(exp_rbase.size()), 128'(0));
  endtask

  task automatic check_status();
    check("records_written", 128'(records_written), 128'(m_rw));
    check("error", 128'(error), 128'(m_err));
    check("free_words", 128'(free_words), 128'(DEPTH - m_base));
    check("full", 128'(full), 128'((DEPTH - m_base) < 3));
    check("busy_idle", 128'(busy), 128'(0));
  endtask

  task automatic pulse_start(input logic [95:0] nv);
    start_record = 1'b1;
    nonce_in     = nv;
    @(negedge clk);
    start_record = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_base = 0; m_rw = 0; m_err = 1'b0;
    check_status();
  endtask

  task automatic run_record(input logic [95:0] nv, input int n, input int gap, input int tdly);
    int  cap, nw, budget;
    bit  ok, aborted;
    aborted = 1'b0;
    if (DEPTH - m_base < 3) begin
      pulse_start(nv);
      m_err = 1'b1;
      check("rej_busy", 128'(busy), 128'(0));
      repeat (3) @(negedge clk);
      check_status();
      return;
    end
    cap = DEPTH - m_base - 2;
    ok  = (n <= cap);
    nw  = ok ? n : cap;
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back(m_base + 1 + i);
      exp_data.push_back(blk[i]);
    end
    if (ok) begin
      exp_addr.push_back(m_base + 1 + n);
      exp_data.push_back(tag_word);
      exp_addr.push_back(m_base);
      exp_data.push_back({nv, 32'(n)});
      exp_rbase.push_back(m_base);
      exp_rwords.push_back(n + 2);
    end
    pulse_start(nv);
    check("start_busy", 128'(busy), 128'(1));
    for (int i = 0; i < n && !aborted; i++) begin
      in_data = blk[i];
      in_last = (i == n - 1);
      budget  = 0;
      forever begin
        if (!busy) begin aborted = 1'b1; break; end
        check("tag_rdy_data", 128'(tag_ready), 128'(0));
        if ($urandom_range(99) < gap) begin
          in_valid = 1'b0;
          @(negedge clk);
        end else begin
          in_valid = 1'b1;
          if (in_ready) begin @(negedge clk); break; end
          @(negedge clk);
        end
        if (++budget > 60) begin
          check("data_timeout", 128'(busy), 128'(0));
          aborted = 1'b1;
          break;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("aborted", 128'(aborted), 128'(!ok));
    if (ok && !aborted) begin
      repeat (tdly) begin
        check("tag_rdy_wait", 128'(tag_ready), 128'(1));
        @(negedge clk);
      end
      tag_valid = 1'b1;
      tag_in    = tag_word;
      budget    = 0;
      while (!tag_ready && budget < 20) begin @(negedge clk); budget++; end
      check("tag_handshake", 128'(tag_ready), 128'(1));
      @(negedge clk);
      tag_valid = 1'b0;
    end
    budget = 0;
    while (busy && budget < 10) begin @(negedge clk); budget++; end
    check("idle_after", 128'(busy), 128'(0));
    if (ok) begin
      m_base += n + 2;
      m_rw++;
      m_err = 1'b0;
    end else m_err = 1'b1;
    drain();
    check_status();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0; start_record = 1'b0; in_valid = 1'b0; in_last = 1'b0; tag_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'({in_ready, tag_ready, record_done, error}), 128'(0));
    check("rst_rec", 128'({records_written, record_words, record_base}), 128'(0));
    check("rst_free", 128'(free_words), 128'(DEPTH));
    rst = 1'b0;
    m_base = 0; m_rw = 0; m_err = 1'b0;
    exp_addr.delete(); exp_data.delete(); exp_rbase.delete(); exp_rwords.delete();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int budget;
    nonce_in = '0; in_data = '0; tag_in = '0;
    do_reset();
    check_status();

    // Single record with fixed payload
    blk[0] = 128'h11; blk[1] = 128'h22; blk[2] = 128'h33; tag_word = 128'hFF;
    run_record(96'hA5000000_00000000_00000001, 3, 0, 0);
    // Back-to-back one-block record
    fill_random(1);
    run_record(96'h1234, 1, 0, 0);
    // Same payload under backpressure and a late tag
    do_clear();
    blk[0] = 128'h11; blk[1] = 128'h22; blk[2] = 128'h33; tag_word = 128'hFF;
    run_record(96'hA5000000_00000000_00000001, 3, 50, 10);
    // Overflow, then recovery
    do_clear();
    fill_random(20);
    run_record(96'hBAD, 20, 0, 0);
    fill_random(2);
    run_record(96'h600D, 2, 0, 1);
    // Fill to free_words = 2, then a rejected start
    do_clear();
    fill_random(3); run_record(96'h1, 3, 10, 0);
    fill_random(3); run_record(96'h2, 3, 10, 2);
    fill_random(2); run_record(96'h3, 2, 10, 1);
    check("free_two", 128'(free_words), 128'(2));
    run_record(96'h4, 1, 0, 0);
    // Clear wins over a simultaneous start
    clear = 1'b1; start_record = 1'b1; nonce_in = 96'h77;
    @(negedge clk);
    clear = 1'b0; start_record = 1'b0;
    m_base = 0; m_rw = 0; m_err = 1'b0;
    @(negedge clk);
    check_status();
    // Reset in the middle of DATA after two blocks
    fill_random(2);
    exp_addr.push_back(1); exp_data.push_back(blk[0]);
    exp_addr.push_back(2); exp_data.push_back(blk[1]);
    pulse_start(96'h99);
    for (int i = 0; i < 2; i++) begin
      in_data = blk[i]; in_valid = 1'b1; budget = 0;
      while (!in_ready && budget < 10) begin @(negedge clk); budget++; end
      check("mid_ready", 128'(in_ready), 128'(1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    do_reset();
    fill_random(2);
    run_record(96'hAB, 2, 20, 1);
    // Randomised records with occasional clear and overflow
    for (int it = 0; it < 20; it++) begin
      int r, n;
      r = $urandom_range(9);
      if (r < 2) do_clear();
      n = (r == 2) ? 20 : $urandom_range(1, 5);
      fill_random(n);
      run_record({$urandom, $urandom, $urandom}, n, $urandom_range(0, 50), $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
